// File: rtl/pipe_pkg.sv
// Shared types and helpers for the in-order pipeline front end.
package pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/pipe_ibuf_fifo.sv
// Synchronous FIFO with push, pop and a single-cycle clear; clear wins over
// any same-cycle push or pop.
module pipe_ibuf_fifo
  import pipe_pkg::clog2;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer tells full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign head_data = mem[rd_ptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pipe_if_buf.sv
// Instruction-fetch stage: issues preIF PCs to a variable-latency memory,
// tracks in-flight requests in pcq, and queues returned instructions for ID.
module pipe_if_buf
  import pipe_pkg::if_entry_t, pipe_pkg::clog2;
#(
  parameter int               XLEN       = 32,
  parameter int               IBUF_DEPTH = 4,
  parameter int               MAX_OUTST  = 2,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  in_pc,
  output logic             in_allowin,
  output logic             inst_req,
  output logic [XLEN-1:0]  inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [XLEN-1:0]  inst_rdata,
  output logic             out_valid,
  input  logic             out_allowin,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  input  logic             flush
);

  localparam int CNT_W = clog2(IBUF_DEPTH) + 1;
  localparam int PQ_IW = (MAX_OUTST > 1) ? clog2(MAX_OUTST) : 1;
  localparam int PQ_CW = clog2(MAX_OUTST + 1);

  logic [XLEN-1:0]      pcq_pc [MAX_OUTST];
  logic [MAX_OUTST-1:0] pcq_kill;
  logic [PQ_IW-1:0]     pcq_head;
  logic [PQ_IW-1:0]     pcq_head_nxt;
  logic [PQ_IW-1:0]     pcq_tail;
  logic [PQ_CW-1:0]     pend;
  int                   tail_sum;

  logic [CNT_W-1:0]     ibuf_cnt;
  logic                 ibuf_empty;
  logic                 ibuf_push;
  logic                 ibuf_pop;
  if_entry_t            push_ent;
  if_entry_t            head_ent;

  logic                 credit;
  logic                 req_fire;
  logic                 resp_fire;
  logic                 head_kill;
  logic [XLEN-1:0]      last_pc;
  logic [XLEN-1:0]      last_inst;

  // Killed entries still hold a credit until their response drains.
  assign credit = (int'(pend) < MAX_OUTST) &&
                  (int'(pend) + int'(ibuf_cnt) < IBUF_DEPTH);

  assign inst_req   = in_valid && credit && !flush && !reset;
  assign in_allowin = credit && inst_addr_ok && !flush && !reset;
  assign inst_addr  = in_pc;

  assign req_fire  = inst_req && inst_addr_ok;
  assign resp_fire = inst_data_ok && (pend != '0);
  assign head_kill = pcq_kill[pcq_head];

  always_comb begin
    tail_sum = int'(pcq_head) + int'(pend);
    if (tail_sum >= MAX_OUTST) tail_sum = tail_sum - MAX_OUTST;
    pcq_tail     = PQ_IW'(tail_sum);
    pcq_head_nxt = (int'(pcq_head) == MAX_OUTST - 1) ? '0 : pcq_head + 1'b1;
  end

  // pcq control: in-order request tracking with a broadcast kill on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcq_head <= '0;
      pend     <= '0;
      pcq_kill <= '0;
    end else begin
      if (resp_fire) pcq_head <= pcq_head_nxt;
      pend <= pend + PQ_CW'(req_fire) - PQ_CW'(resp_fire);
      for (int i = 0; i < MAX_OUTST; i++) begin
        if (flush) pcq_kill[i] <= 1'b1;
        else if (req_fire && (int'(pcq_tail) == i)) pcq_kill[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq_pc[pcq_tail] <= in_pc;
  end

  // Response stage: surviving data enters ibuf and is visible to ID next cycle.
  assign ibuf_push = resp_fire && !head_kill && !flush;
  assign ibuf_pop  = !ibuf_empty && out_allowin;
  assign push_ent  = '{pc: pcq_pc[pcq_head], inst: inst_rdata};

  pipe_ibuf_fifo #(
    .WIDTH ($bits(if_entry_t)),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (ibuf_push),
    .push_data (push_ent),
    .pop       (ibuf_pop),
    .head_data (head_ent),
    .empty     (ibuf_empty),
    .count     (ibuf_cnt)
  );

  // Output holds the last instruction handed to ID while the buffer is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc   <= RESET_PC;
      last_inst <= '0;
    end else if (ibuf_pop) begin
      last_pc   <= head_ent.pc;
      last_inst <= head_ent.inst;
    end
  end

  assign out_valid = !ibuf_empty;
  assign out_pc    = ibuf_empty ? last_pc   : head_ent.pc;
  assign out_inst  = ibuf_empty ? last_inst : head_ent.inst;

endmodule

// File: tb/tb_pipe_if_buf.sv
// Directed-vector bench for pipe_if_buf; the bench itself plays preIF, the
// instruction memory and ID, one table row per clock cycle.
module tb_pipe_if_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_pc;
  logic        in_allowin;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_allowin;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        flush;

  int checks   = 0;
  int failures = 0;
  int outst    = 0;

  always #5 clk = ~clk;

  pipe_if_buf #(
    .XLEN       (32),
    .IBUF_DEPTH (4),
    .MAX_OUTST  (2),
    .RESET_PC   (32'h0)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_pc        (in_pc),
    .in_allowin   (in_allowin),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .out_valid    (out_valid),
    .out_allowin  (out_allowin),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .flush        (flush)
  );

  typedef struct {
    string       name;
    logic        rst, iv;
    logic [31:0] ipc;
    logic        aok, dok;
    logic [31:0] rd;
    logic        oa, fl;
    logic        ereq, eal, eov, cpc;
    logic [31:0] epc, ei;
  } vec_t;

  function automatic vec_t v(string name, logic rst, logic iv, logic [31:0] ipc,
                             logic aok, logic dok, logic [31:0] rd, logic oa,
                             logic fl, logic ereq, logic eal, logic eov,
                             logic cpc, logic [31:0] epc, logic [31:0] ei);
    vec_t t;
    t.name = name; t.rst = rst; t.iv = iv; t.ipc = ipc; t.aok = aok;
    t.dok = dok; t.rd = rd; t.oa = oa; t.fl = fl; t.ereq = ereq;
    t.eal = eal; t.eov = eov; t.cpc = cpc; t.epc = epc; t.ei = ei;
    return t;
  endfunction

  function automatic logic [31:0] D(logic [31:0] pc);
    return 32'hCAFE0000 | pc;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(vec_t t);
    logic fire;
    @(negedge clk);
    reset        = t.rst;
    in_valid     = t.iv;
    in_pc        = t.ipc;
    inst_addr_ok = t.aok;
    inst_data_ok = t.dok;
    inst_rdata   = t.rd;
    out_allowin  = t.oa;
    flush        = t.fl;
    #1;
    chk({t.name, ".inst_req"},   32'(inst_req),   32'(t.ereq));
    chk({t.name, ".in_allowin"}, 32'(in_allowin), 32'(t.eal));
    chk({t.name, ".out_valid"},  32'(out_valid),  32'(t.eov));
    if (inst_req) chk({t.name, ".inst_addr"}, inst_addr, t.ipc);
    if (t.cpc) begin
      chk({t.name, ".out_pc"},   out_pc,   t.epc);
      chk({t.name, ".out_inst"}, out_inst, t.ei);
    end
    if (t.dok && !t.rst) begin
      checks++;
      if (outst == 0) begin
        failures++;
        $display("FAIL %s.protocol: data_ok with %0d outstanding required >0", t.name, outst);
      end
    end
    fire = inst_req && inst_addr_ok;
    @(posedge clk);
    if (t.rst) outst = 0;
    else       outst = outst + int'(fire) - int'(t.dok);
  endtask

  localparam logic [31:0] H = 32'h02800413;

  vec_t tbl[$];

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_pc = '0; inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0; inst_rdata = '0; out_allowin = 1'b0; flush = 1'b0;

    //                  name   rst iv ipc       aok dok rd        oa fl  req al ov cpc epc      ei
    // Reset and single fetch with a 1-cycle memory.
    tbl.push_back(v("rst0",  1, 0, 0,        0, 0, 0,        0, 0,  0, 0, 0, 1, 0,       0));
    tbl.push_back(v("rst1",  1, 0, 0,        0, 0, 0,        0, 0,  0, 0, 0, 1, 0,       0));
    tbl.push_back(v("a1",    0, 1, 'h100,    1, 0, 0,        0, 0,  1, 1, 0, 1, 0,       0));
    tbl.push_back(v("a2",    0, 0, 0,        1, 1, H,        0, 0,  0, 1, 0, 1, 0,       0));
    tbl.push_back(v("a3",    0, 0, 0,        1, 0, 0,        0, 0,  0, 1, 1, 1, 'h100,   H));
    tbl.push_back(v("a4",    0, 0, 0,        1, 0, 0,        1, 0,  0, 1, 1, 1, 'h100,   H));
    tbl.push_back(v("a5",    0, 0, 0,        1, 0, 0,        0, 0,  0, 1, 0, 1, 'h100,   H));
    // Back-to-back stream, one instruction per cycle.
    tbl.push_back(v("b0",    0, 1, 'h0,      1, 0, 0,        1, 0,  1, 1, 0, 1, 'h100,   H));
    tbl.push_back(v("b1",    0, 1, 'h4,      1, 1, D('h0),   1, 0,  1, 1, 0, 1, 'h100,   H));
    tbl.push_back(v("b2",    0, 1, 'h8,      1, 1, D('h4),   1, 0,  1, 1, 1, 1, 'h0,     D('h0)));
    tbl.push_back(v("b3",    0, 1, 'hC,      1, 1, D('h8),   1, 0,  1, 1, 1, 1, 'h4,     D('h4)));
    tbl.push_back(v("b4",    0, 0, 0,        1, 1, D('hC),   1, 0,  0, 1, 1, 1, 'h8,     D('h8)));
    tbl.push_back(v("b5",    0, 0, 0,        1, 0, 0,        1, 0,  0, 1, 1, 1, 'hC,     D('hC)));
    tbl.push_back(v("b6",    0, 0, 0,        1, 0, 0,        1, 0,  0, 1, 0, 1, 'hC,     D('hC)));
    // Backpressure: buffer fills to 4, then one pop frees exactly one request.
    tbl.push_back(v("c0",    0, 1, 'h300,    1, 0, 0,        0, 0,  1, 1, 0, 1, 'hC,     D('hC)));
    tbl.push_back(v("c1",    0, 1, 'h304,    1, 1, D('h300), 0, 0,  1, 1, 0, 1, 'hC,     D('hC)));
    tbl.push_back(v("c2",    0, 1, 'h308,    1, 1, D('h304), 0, 0,  1, 1, 1, 1, 'h300,   D('h300)));
    tbl.push_back(v("c3",    0, 1, 'h30C,    1, 1, D('h308), 0, 0,  1, 1, 1, 1, 'h300,   D('h300)));
    tbl.push_back(v("c4",    0, 1, 'h310,    1, 1, D('h30C), 0, 0,  0, 0, 1, 1, 'h300,   D('h300)));
    tbl.push_back(v("c5",    0, 1, 'h310,    1, 0, 0,        0, 0,  0, 0, 1, 1, 'h300,   D('h300)));
    tbl.push_back(v("c6",    0, 1, 'h310,    1, 0, 0,        1, 0,  0, 0, 1, 1, 'h300,   D('h300)));
    tbl.push_back(v("c7",    0, 1, 'h310,    1, 0, 0,        0, 0,  1, 1, 1, 1, 'h304,   D('h304)));
    tbl.push_back(v("c8",    0, 1, 'h314,    1, 0, 0,        0, 0,  0, 0, 1, 1, 'h304,   D('h304)));
    tbl.push_back(v("c9",    0, 1, 'h314,    1, 1, D('h310), 0, 0,  0, 0, 1, 1, 'h304,   D('h304)));
    tbl.push_back(v("c10",   0, 1, 'h314,    1, 0, 0,        0, 0,  0, 0, 1, 1, 'h304,   D('h304)));
    tbl.push_back(v("c11",   0, 0, 0,        1, 0, 0,        1, 0,  0, 0, 1, 1, 'h304,   D('h304)));
    tbl.push_back(v("c12",   0, 0, 0,        1, 0, 0,        1, 0,  0, 1, 1, 1, 'h308,   D('h308)));
    tbl.push_back(v("c13",   0, 0, 0,        1, 0, 0,        1, 0,  0, 1, 1, 1, 'h30C,   D('h30C)));
    tbl.push_back(v("c14",   0, 0, 0,        1, 0, 0,        1, 0,  0, 1, 1, 1, 'h310,   D('h310)));
    tbl.push_back(v("c15",   0, 0, 0,        1, 0, 0,        0, 0,  0, 1, 0, 1, 'h310,   D('h310)));

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // Flush with two requests in flight and one instruction buffered.
    cyc(v("f0",  0, 1, 'h400, 1, 0, 0,        0, 0,  1, 1, 0, 1, 'h310, D('h310)));
    cyc(v("f1",  0, 1, 'h404, 1, 1, D('h400), 0, 0,  1, 1, 0, 1, 'h310, D('h310)));
    cyc(v("f2",  0, 1, 'h408, 1, 0, 0,        0, 0,  1, 1, 1, 1, 'h400, D('h400)));
    cyc(v("f3",  0, 1, 'h408, 1, 0, 0,        0, 1,  0, 0, 1, 1, 'h400, D('h400)));
    cyc(v("f4",  0, 1, 'h200, 1, 1, D('h404), 0, 0,  0, 0, 0, 1, 'h310, D('h310)));
    cyc(v("f5",  0, 1, 'h200, 1, 1, D('h408), 0, 0,  1, 1, 0, 1, 'h310, D('h310)));
    cyc(v("f6",  0, 0, 0,     1, 1, D('h200), 0, 0,  0, 1, 0, 1, 'h310, D('h310)));
    cyc(v("f7",  0, 0, 0,     1, 0, 0,        1, 0,  0, 1, 1, 1, 'h200, D('h200)));
    cyc(v("f8",  0, 0, 0,     1, 0, 0,        0, 0,  0, 1, 0, 1, 'h200, D('h200)));

    // Flush in the same cycle as a response and an ID pop.
    cyc(v("g0",  0, 1, 'h500, 1, 0, 0,        0, 0,  1, 1, 0, 1, 'h200, D('h200)));
    cyc(v("g1",  0, 1, 'h504, 1, 1, D('h500), 0, 0,  1, 1, 0, 1, 'h200, D('h200)));
    cyc(v("g2",  0, 1, 'h508, 1, 1, D('h504), 1, 1,  0, 0, 1, 1, 'h500, D('h500)));
    cyc(v("g3",  0, 1, 'h600, 1, 0, 0,        0, 0,  1, 1, 0, 0, 0,     0));
    cyc(v("g4",  0, 0, 0,     1, 1, D('h600), 0, 0,  0, 1, 0, 0, 0,     0));
    cyc(v("g5",  0, 0, 0,     1, 0, 0,        1, 0,  0, 1, 1, 1, 'h600, D('h600)));
    cyc(v("g6",  0, 0, 0,     1, 0, 0,        0, 0,  0, 1, 0, 1, 'h600, D('h600)));

    // Reset mid-operation, then a clean fetch.
    cyc(v("h0",  0, 1, 'h700, 1, 0, 0,        0, 0,  1, 1, 0, 1, 'h600, D('h600)));
    cyc(v("h1",  0, 1, 'h704, 1, 1, D('h700), 0, 0,  1, 1, 0, 1, 'h600, D('h600)));
    cyc(v("h2",  0, 1, 'h708, 1, 0, 0,        0, 0,  1, 1, 1, 1, 'h700, D('h700)));
    cyc(v("h3",  1, 0, 0,     0, 0, 0,        0, 0,  0, 0, 1, 1, 'h700, D('h700)));
    cyc(v("h4",  0, 0, 0,     0, 0, 0,        0, 0,  0, 0, 0, 1, 0,     0));
    cyc(v("h5",  0, 1, 'h800, 1, 0, 0,        0, 0,  1, 1, 0, 1, 0,     0));
    cyc(v("h6",  0, 0, 0,     1, 1, D('h800), 0, 0,  0, 1, 0, 1, 0,     0));
    cyc(v("h7",  0, 0, 0,     1, 0, 0,        1, 0,  0, 1, 1, 1, 'h800, D('h800)));
    cyc(v("h8",  0, 0, 0,     1, 0, 0,        0, 0,  0, 1, 0, 1, 'h800, D('h800)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
